// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands and adds them LSB-first,
// one bit per clock, through a single full-adder slice and a carry register.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sBit;
  logic             halfSum;

  // Partial result lives in result_q; sum_q only changes on the final RUN edge.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    result_d = result_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    co_d     = co_q;
    count_d  = count_q;

    halfSum = aShift_q[0] ^ bShift_q[0];
    sBit    = halfSum ^ carry_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          aShift_d = a;
          bShift_d = b;
          result_d = '0;
          carry_d  = 1'b0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        result_d = {sBit, result_q[WIDTH-1:1]};
        carry_d  = (aShift_q[0] & bShift_q[0]) | (carry_q & halfSum);
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          sum_d   = {sBit, result_q[WIDTH-1:1]};
          co_d    = (aShift_q[0] & bShift_q[0]) | (carry_q & halfSum);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      result_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      result_q <= result_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      count_q  <= count_d;
    end
  end

  assign sum  = sum_q;
  assign co   = co_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): hand-computed sums, fixed-latency
// protocol checks, start glitch during RUN, mid-RUN reset and back-to-back starts.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       co;
  logic       busy;
  logic       done;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] prevSum = 8'h00;
  logic       prevCo  = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .co   (co),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents operands with start for exactly one edge; returns on the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runOp(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] expSum, input logic expCo, input int glitchAt);
    int doneSeen;
    doneSeen = 0;
    applyStimulus(av, bv);
    for (int i = 0; i < 8; i++) begin
      if (i == glitchAt) begin
        start = 1'b1;
        a     = ~av;
        b     = 8'h5A;
      end else begin
        start = 1'b0;
      end
      checkOutput("busyRun", busy, 1);
      checkOutput("doneRun", done, 0);
      checkOutput("sumHold", sum, prevSum);
      checkOutput("coHold", co, prevCo);
      if (done) doneSeen++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("donePulse", done, 1);
    checkOutput("busyDone", busy, 0);
    checkOutput("sum", sum, expSum);
    checkOutput("co", co, expCo);
    if (done) doneSeen++;
    @(negedge clk);
    checkOutput("doneDrop", done, 0);
    checkOutput("busyIdle", busy, 0);
    if (done) doneSeen++;
    @(negedge clk);
    checkOutput("noQueue", busy, 0);
    if (done) doneSeen++;
    checkOutput("doneCount", doneSeen, 1);
    checkOutput("sumStable", sum, expSum);
    prevSum = expSum;
    prevCo  = expCo;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rstSum", sum, 0);
    checkOutput("rstCo", co, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    rst = 1'b0;

    runOp(8'h0F, 8'h01, 8'h10, 1'b0, -1);
    runOp(8'hFF, 8'h01, 8'h00, 1'b1, -1);
    runOp(8'hFF, 8'hFF, 8'hFE, 1'b1, -1);
    runOp(8'h00, 8'h00, 8'h00, 1'b0, -1);
    runOp(8'h3C, 8'h5A, 8'h96, 1'b0, 2);
    runOp(8'hC8, 8'h64, 8'h2C, 1'b1, -1);

    // Reset in the middle of RUN discards the operation.
    applyStimulus(8'hAA, 8'h55);
    repeat (3) begin
      checkOutput("busyPreRst", busy, 1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstSum", sum, 0);
    checkOutput("midRstCo", co, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("noDoneAfterRst", done, 0);
      checkOutput("idleAfterRst", busy, 0);
      @(negedge clk);
    end
    prevSum = 8'h00;
    prevCo  = 1'b0;
    runOp(8'h12, 8'h34, 8'h46, 1'b0, -1);

    // Start held high: one operation every 10 cycles.
    a     = 8'h80;
    b     = 8'h80;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      checkOutput("b2bBusy", busy, ((k % 10) < 8) ? 1 : 0);
      checkOutput("b2bDone", done, ((k % 10) == 8) ? 1 : 0);
      if ((k % 10) == 8) begin
        checkOutput("b2bSum", sum, 8'h00);
        checkOutput("b2bCo", co, 1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("finalIdle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a and b; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: addend A; captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: addend B; captured on the accepted start edge.
REQ-007 The block SHALL have port sum, output, WIDTH bits: registered result, (a+b) mod 2^WIDTH.
REQ-008 The block SHALL have port co, output, 1 bit: registered carry-out of the addition.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.

Function
REQ-011 The block SHALL implement an FSM with exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the next edge SHALL perform all of the following: load a and b into internal shift registers, clear the carry flip-flop, clear the bit counter, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL hold all state, including sum and co.
REQ-014 In RUN, each edge SHALL process one bit pair LSB-first: s_bit = a0 ^ b0 ^ c, and c <= (a0&b0) | (c&(a0^b0)), i.e. two cascaded half-add stages plus a carry register.
REQ-015 In RUN, each edge SHALL shift both operand registers right by one and shift s_bit into the result register at its MSB.
REQ-016 In RUN, each edge SHALL increment the counter by 1.
REQ-017 RUN SHALL last exactly WIDTH cycles.
REQ-018 On the WIDTH-th RUN edge, the block SHALL update sum with the complete result and co with the final carry, and SHALL enter DONE.
REQ-019 DONE SHALL last one cycle, with done=1 and busy=0, then SHALL return to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: for start accepted at edge E0, busy=1 during cycles E0..E(WIDTH-1), sum/co are valid after edge E(WIDTH), and done=1 in cycle E(WIDTH)..E(WIDTH+1).
REQ-021 The block SHALL hold sum and co stable from DONE until the completion of the next accepted operation; intermediate RUN shifting SHALL NOT be visible on sum.
REQ-022 The block SHALL ignore start while in RUN or DONE (no queuing), and changes on a or b after acceptance SHALL NOT affect the result.
REQ-023 The block SHALL accept start asserted in the IDLE cycle immediately after DONE; back-to-back throughput SHALL be one operation per WIDTH+2 cycles.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during legal operation.
REQ-025 Carry-out SHALL be correct at the overflow boundary; for all-ones + all-ones, sum SHALL be all-ones except the LSB and co SHALL be 1.

Reset
REQ-026 With rst=1 at an edge, the block SHALL force the FSM to IDLE; sum, co, busy, done, the counter, the carry and both shift registers to 0.
REQ-027 rst SHALL take priority over start and over any in-flight operation; an operation interrupted mid-RUN SHALL be discarded with no done pulse.
REQ-028 The first start SHALL be accepted at the first edge after the rst=0 edge.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover: a=0x0F, b=0x01, start → after 8 busy cycles, done pulse with sum=0x10, co=0.
REQ-030 The bench SHALL cover: a=0xFF, b=0x01 → sum=0x00, co=1.
REQ-031 The bench SHALL cover: a=0xFF, b=0xFF → sum=0xFE, co=1; and a=0x00, b=0x00 → sum=0x00, co=0, with done still pulsing.
REQ-032 The bench SHALL cover: start re-pulsed at cycle 3 of RUN with different operands → ignored, first result delivered unchanged, and exactly one done.
REQ-033 The bench SHALL cover: rst=1 at RUN cycle 4 → next cycle all outputs 0 and state IDLE, no done; then a=0x12, b=0x34 → sum=0x46, co=0.
REQ-034 The bench SHALL cover: start held high continuously with a=0x80, b=0x80 → done every 10 cycles, sum=0x00, co=1 each time, and busy low in DONE and IDLE.
